// File: rtl/valve_ctrl_pkg.sv
// Shared encodings for the valve chain sequencer.
//   op_e    : command opcodes carried on cmd_op
//   state_e : sequencer FSM states
package valve_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_HOLD     = 2'd0,
    OP_PUMP_FWD = 2'd1,
    OP_PUMP_REV = 2'd2,
    OP_FLUSH    = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HOLD   = 3'd1,
    PUMP   = 3'd2,
    FLUSH  = 3'd3,
    SETTLE = 3'd4
  } state_e;

endpackage

// File: rtl/valve_dwell_timer.sv
// Per-phase dwell timer for the valve chain sequencer.
//   clk, rst_n : clock, synchronous active-low reset
//   i_load     : capture i_dwell (0 treated as 1) and restart the count
//   i_dwell    : dwell length in cycles
//   i_en       : count while a command is executing
//   o_expire   : high on the last cycle of each D-cycle phase; the count
//                restarts by itself so consecutive phases are back to back
module valve_dwell_timer
  import valve_ctrl_pkg::*;
#(
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic [DWELL_W-1:0] i_dwell,
  input  logic               i_en,
  output logic               o_expire
);

  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] w_dwell_clamped;

  assign w_dwell_clamped = (i_dwell == '0) ? DWELL_W'(1) : i_dwell;
  assign o_expire        = i_en && (r_cnt == (r_dwell - DWELL_W'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dwell <= DWELL_W'(1);
      r_cnt   <= '0;
    end else if (i_load) begin
      r_dwell <= w_dwell_clamped;
      r_cnt   <= '0;
    end else if (i_en) begin
      if (o_expire) r_cnt <= '0;
      else          r_cnt <= r_cnt + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/valve_chain_sequencer.sv
// Air-line sequencer for a serial valve chain. Accepts HOLD / PUMP_FWD /
// PUMP_REV / FLUSH commands over valid/ready and drives air_ctrl
// (1 = pressurised = valve closed, 0 = vented = valve open).
//   clk, rst_n           : clock, synchronous active-low reset
//   cmd_valid/cmd_ready  : command handshake (ready only in IDLE)
//   cmd_op, cmd_arg      : opcode and stroke count (PUMP only)
//   cmd_pattern          : HOLD air pattern
//   dwell_cfg            : cycles per phase, 0 treated as 1
//   abort                : abandon the running command
//   air_ctrl             : air line drive, bit i -> valve i
//   busy, stroke_cnt     : status
//   done, aborted        : end-of-command pulse and its cause
module valve_chain_sequencer
  import valve_ctrl_pkg::*;
#(
  parameter int unsigned NUM_VALVES = 4,
  parameter int unsigned DWELL_W    = 16,
  parameter int unsigned STROKE_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [STROKE_W-1:0]   cmd_arg,
  input  logic [NUM_VALVES-1:0] cmd_pattern,
  input  logic [DWELL_W-1:0]    dwell_cfg,
  input  logic                  abort,
  output logic [NUM_VALVES-1:0] air_ctrl,
  output logic                  busy,
  output logic [STROKE_W-1:0]   stroke_cnt,
  output logic                  done,
  output logic                  aborted
);

  localparam int unsigned PW = (NUM_VALVES > 1) ? $clog2(NUM_VALVES) : 1;
  localparam logic [PW-1:0] LAST_PH = PW'(NUM_VALVES - 1);

  state_e                r_state, w_state_nxt;
  op_e                   r_op;
  logic [STROKE_W-1:0]   r_arg;
  logic [NUM_VALVES-1:0] r_air, w_air_nxt;
  logic [PW-1:0]         r_phase, w_phase_nxt;
  logic [STROKE_W-1:0]   r_stroke, w_stroke_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_aborted, w_aborted_nxt;
  logic                  w_accept;
  logic                  w_expire;
  logic                  w_rev;
  logic [STROKE_W-1:0]   w_stroke_inc;

  // Pump phase p vents exactly one valve; reverse walks the chain backwards.
  function automatic logic [NUM_VALVES-1:0] pump_pat(input logic [PW-1:0] p,
                                                     input logic rev);
    logic [NUM_VALVES-1:0] pat;
    logic [PW-1:0]         v;
    v      = rev ? (LAST_PH - p) : p;
    pat    = '1;
    pat[v] = 1'b0;
    return pat;
  endfunction

  assign w_accept     = cmd_valid && (r_state == IDLE);
  assign w_rev        = (r_op == OP_PUMP_REV);
  assign w_stroke_inc = r_stroke + STROKE_W'(1);

  valve_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_accept),
    .i_dwell  (dwell_cfg),
    .i_en     (r_state != IDLE),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_air_nxt     = r_air;
    w_phase_nxt   = r_phase;
    w_stroke_nxt  = r_stroke;
    w_done_nxt    = 1'b0;
    w_aborted_nxt = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_stroke_nxt = '0;
          w_phase_nxt  = '0;
          case (op_e'(cmd_op))
            OP_HOLD: begin
              w_state_nxt = HOLD;
              w_air_nxt   = cmd_pattern;
            end
            OP_FLUSH: begin
              w_state_nxt = FLUSH;
              w_air_nxt   = '0;
            end
            default: begin
              // Zero-stroke pump completes immediately without touching the air lines.
              if (cmd_arg == '0) begin
                w_done_nxt = 1'b1;
              end else begin
                w_state_nxt = PUMP;
                w_air_nxt   = pump_pat('0, op_e'(cmd_op) == OP_PUMP_REV);
              end
            end
          endcase
        end
      end
      HOLD, SETTLE: begin
        if (w_expire) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      FLUSH: begin
        if (w_expire) begin
          w_state_nxt = SETTLE;
          w_air_nxt   = '1;
        end
      end
      PUMP: begin
        if (w_expire) begin
          if (r_phase == LAST_PH) begin
            w_phase_nxt  = '0;
            w_stroke_nxt = w_stroke_inc;
            if (w_stroke_inc == r_arg) begin
              w_state_nxt = SETTLE;
              w_air_nxt   = '1;
            end else begin
              w_air_nxt = pump_pat('0, w_rev);
            end
          end else begin
            w_phase_nxt = r_phase + PW'(1);
            w_air_nxt   = pump_pat(r_phase + PW'(1), w_rev);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Abort overrides any expiry handled above, including a stroke increment.
    if (abort && (r_state != IDLE)) begin
      w_state_nxt   = IDLE;
      w_air_nxt     = '1;
      w_phase_nxt   = r_phase;
      w_stroke_nxt  = r_stroke;
      w_done_nxt    = 1'b1;
      w_aborted_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_op      <= OP_HOLD;
      r_arg     <= '0;
      r_air     <= '1;
      r_phase   <= '0;
      r_stroke  <= '0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_air     <= w_air_nxt;
      r_phase   <= w_phase_nxt;
      r_stroke  <= w_stroke_nxt;
      r_done    <= w_done_nxt;
      r_aborted <= w_aborted_nxt;
      if (w_accept) begin
        r_op  <= op_e'(cmd_op);
        r_arg <= cmd_arg;
      end
    end
  end

  assign cmd_ready  = (r_state == IDLE);
  assign busy       = (r_state != IDLE) || r_done;
  assign air_ctrl   = r_air;
  assign stroke_cnt = r_stroke;
  assign done       = r_done;
  assign aborted    = r_aborted;

endmodule

// File: tb/tb_valve_chain_sequencer.sv
module tb_valve_chain_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_arg;
  logic [3:0]  cmd_pattern;
  logic [15:0] dwell_cfg;
  logic        abort;
  logic [3:0]  air_ctrl;
  logic        busy;
  logic [7:0]  stroke_cnt;
  logic        done;
  logic        aborted;

  valve_chain_sequencer #(.NUM_VALVES(4), .DWELL_W(16), .STROKE_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_arg     (cmd_arg),
    .cmd_pattern (cmd_pattern),
    .dwell_cfg   (dwell_cfg),
    .abort       (abort),
    .air_ctrl    (air_ctrl),
    .busy        (busy),
    .stroke_cnt  (stroke_cnt),
    .done        (done),
    .aborted     (aborted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] air;
    logic       done;
  } exp_t;

  exp_t       q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         accepts  = 0;
  logic [3:0] cur_air;

  always @(posedge clk)
    if (rst_n && cmd_valid && cmd_ready) accepts++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected per-cycle air/done trace for one command, from accept+1 to done.
  task automatic model_push(input logic [1:0] op, input int unsigned n,
                            input logic [3:0] pat, input int unsigned d);
    exp_t e;
    q.delete();
    if (op == 2'd0) begin
      for (int unsigned c = 0; c < d; c++) begin e.air = pat; e.done = 1'b0; q.push_back(e); end
      e.air = pat; e.done = 1'b1; q.push_back(e);
    end else if (op == 2'd3) begin
      for (int unsigned c = 0; c < d; c++) begin e.air = 4'b0000; e.done = 1'b0; q.push_back(e); end
      for (int unsigned c = 0; c < d; c++) begin e.air = 4'b1111; e.done = 1'b0; q.push_back(e); end
      e.air = 4'b1111; e.done = 1'b1; q.push_back(e);
    end else if (n == 0) begin
      e.air = cur_air; e.done = 1'b1; q.push_back(e);
    end else begin
      for (int unsigned s = 0; s < n; s++)
        for (int unsigned p = 0; p < 4; p++) begin
          int unsigned v;
          v = (op == 2'd2) ? 3 - p : p;
          e.air = 4'b1111;
          e.air[v] = 1'b0;
          e.done = 1'b0;
          for (int unsigned c = 0; c < d; c++) q.push_back(e);
        end
      for (int unsigned c = 0; c < d; c++) begin e.air = 4'b1111; e.done = 1'b0; q.push_back(e); end
      e.air = 4'b1111; e.done = 1'b1; q.push_back(e);
    end
  endtask

  task automatic run_cmd(input string name, input logic [1:0] op, input logic [7:0] arg,
                         input logic [3:0] pat, input logic [15:0] dw, input bit hold_valid);
    int unsigned d;
    int          a0;
    int unsigned cyc;
    exp_t        e;
    logic [7:0]  exp_stroke;
    d = (dw == 16'd0) ? 1 : int'(dw);
    exp_stroke = (op == 2'd1 || op == 2'd2) ? arg : 8'd0;
    model_push(op, arg, pat, d);
    a0 = accepts;
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg; cmd_pattern = pat; dwell_cfg = dw;
    step();
    if (!hold_valid) cmd_valid = 1'b0;
    // Inputs changed while busy must be ignored.
    cmd_arg = arg + 8'd3; cmd_pattern = ~pat; dwell_cfg = 16'd7;
    cyc = 1;
    e = '0;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("%s_air_c%0d", name, cyc), air_ctrl, e.air);
      chk($sformatf("%s_done_c%0d", name, cyc), done, e.done);
      chk($sformatf("%s_busy_c%0d", name, cyc), busy, 1);
      if (e.done) begin
        chk($sformatf("%s_aborted", name), aborted, 0);
        chk($sformatf("%s_stroke", name), stroke_cnt, exp_stroke);
        cmd_valid = 1'b0;
      end else begin
        chk($sformatf("%s_ready_c%0d", name, cyc), cmd_ready, 0);
      end
      if (q.size() > 0) begin step(); cyc++; end
    end
    step();
    chk($sformatf("%s_idle_busy", name), busy, 0);
    chk($sformatf("%s_idle_done", name), done, 0);
    chk($sformatf("%s_idle_ready", name), cmd_ready, 1);
    chk($sformatf("%s_idle_air", name), air_ctrl, e.air);
    chk($sformatf("%s_idle_stroke", name), stroke_cnt, exp_stroke);
    chk($sformatf("%s_accepts", name), accepts - a0, 1);
    cur_air = e.air;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = 8'd0;
    cmd_pattern = 4'd0; dwell_cfg = 16'd0; abort = 1'b0;
    step(); step();
    chk("rst_air", air_ctrl, 4'b1111);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_stroke", stroke_cnt, 0);
    rst_n = 1'b1;
    cur_air = 4'b1111;
    step();

    // HOLD with cmd_valid kept high through busy: one accept only.
    run_cmd("hold", 2'd0, 8'd0, 4'b0101, 16'd3, 1'b1);
    step();
    chk("hold_retained", air_ctrl, 4'b0101);

    // Zero-stroke pump: done next cycle, pattern untouched.
    run_cmd("pump0", 2'd1, 8'd0, 4'b0000, 16'd2, 1'b0);

    run_cmd("fwd", 2'd1, 8'd2, 4'b0000, 16'd2, 1'b0);
    run_cmd("rev", 2'd2, 8'd1, 4'b0000, 16'd0, 1'b0);
    run_cmd("flush", 2'd3, 8'd0, 4'b0000, 16'd1, 1'b0);

    // Abort in IDLE is ignored.
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("idle_abort_done", done, 0);
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_air", air_ctrl, 4'b1111);

    // Abort during phase 2 of a 5-stroke forward pump.
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_arg = 8'd5; dwell_cfg = 16'd2;
    step();
    cmd_valid = 1'b0;
    chk("ab_c1", air_ctrl, 4'b1110); step();
    chk("ab_c2", air_ctrl, 4'b1110); step();
    chk("ab_c3", air_ctrl, 4'b1101); step();
    chk("ab_c4", air_ctrl, 4'b1101); step();
    chk("ab_c5", air_ctrl, 4'b1011);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_air", air_ctrl, 4'b1111);
    chk("ab_done", done, 1);
    chk("ab_aborted", aborted, 1);
    chk("ab_busy", busy, 1);
    chk("ab_ready", cmd_ready, 1);
    chk("ab_stroke", stroke_cnt, 0);
    step();
    chk("ab_after_done", done, 0);
    chk("ab_after_aborted", aborted, 0);
    chk("ab_after_busy", busy, 0);
    chk("ab_after_ready", cmd_ready, 1);

    // Reset in the middle of a FLUSH.
    cmd_valid = 1'b1; cmd_op = 2'd3; dwell_cfg = 16'd4;
    step();
    cmd_valid = 1'b0;
    chk("fr_c1", air_ctrl, 4'b0000); step();
    chk("fr_c2", air_ctrl, 4'b0000);
    rst_n = 1'b0;
    step();
    chk("fr_air", air_ctrl, 4'b1111);
    chk("fr_busy", busy, 0);
    chk("fr_ready", cmd_ready, 1);
    chk("fr_done", done, 0);
    rst_n = 1'b1;
    step(); step(); step(); step(); step();
    chk("fr_stays_idle_air", air_ctrl, 4'b1111);
    chk("fr_stays_idle_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
